// File: rtl/uart_baud_gen.sv
// Fractional-N UART baud tick generator: a phase accumulator whose carry produces the
// oversample strobe, plus an oversample counter that derives the mid-bit and bit strobes.
module uart_baud_gen #(
  parameter int unsigned ACC_W       = 24,
  parameter int unsigned OVS         = 16,
  parameter int unsigned DEFAULT_INC = 629146
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             en,
  input  logic             restart,
  input  logic             inc_wr,
  input  logic [ACC_W-1:0] inc_in,
  output logic [ACC_W-1:0] inc_out,
  output logic             ovs_tick,
  output logic             half_tick,
  output logic             bit_tick,
  output logic             active
);

  localparam int unsigned CntW = $clog2(OVS);
  localparam logic [CntW-1:0] CntLast = CntW'(OVS - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(OVS / 2 - 1);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] inc_q;
  logic [CntW-1:0]  cnt_q;
  logic [CntW-1:0]  cnt_d;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic             ovs_q;
  logic             half_q;
  logic             bit_q;
  logic             active_q;

  // One extra bit holds the overflow that becomes the oversample tick.
  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, inc_q};
    carry = sum[ACC_W];
    cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      acc_q    <= '0;
      inc_q    <= ACC_W'(DEFAULT_INC);
      cnt_q    <= '0;
      ovs_q    <= 1'b0;
      half_q   <= 1'b0;
      bit_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      active_q <= en && (inc_q != '0);
      if (inc_wr) begin
        inc_q <= inc_in;
      end
      // Restart wins over accumulation and works even while disabled.
      if (restart) begin
        acc_q  <= '0;
        cnt_q  <= '0;
        ovs_q  <= 1'b0;
        half_q <= 1'b0;
        bit_q  <= 1'b0;
      end else if (en) begin
        acc_q  <= sum[ACC_W-1:0];
        ovs_q  <= carry;
        half_q <= carry && (cnt_q == CntHalf);
        bit_q  <= carry && (cnt_q == CntLast);
        if (carry) begin
          cnt_q <= cnt_d;
        end
      end else begin
        ovs_q  <= 1'b0;
        half_q <= 1'b0;
        bit_q  <= 1'b0;
      end
    end
  end

  assign inc_out   = inc_q;
  assign ovs_tick  = ovs_q;
  assign half_tick = half_q;
  assign bit_tick  = bit_q;
  assign active    = active_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Scoreboard bench for uart_baud_gen: stimulus queues expected tick events with their cycle
// numbers, a negedge monitor pops and compares whenever any tick is presented.
module tb_uart_baud_gen;

  localparam int unsigned AccW = 24;

  logic            sysclk = 1'b0;
  logic            reset  = 1'b1;
  logic            en     = 1'b0;
  logic            restart = 1'b0;
  logic            inc_wr = 1'b0;
  logic [AccW-1:0] inc_in = '0;
  logic [AccW-1:0] inc_out;
  logic            ovs_tick;
  logic            half_tick;
  logic            bit_tick;
  logic            active;

  uart_baud_gen #(
    .ACC_W      (24),
    .OVS        (16),
    .DEFAULT_INC(629146)
  ) dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .en       (en),
    .restart  (restart),
    .inc_wr   (inc_wr),
    .inc_in   (inc_in),
    .inc_out  (inc_out),
    .ovs_tick (ovs_tick),
    .half_tick(half_tick),
    .bit_tick (bit_tick),
    .active   (active)
  );

  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  typedef struct {
    int   c;
    logic o;
    logic h;
    logic b;
  } exp_t;

  exp_t exp_q[$];
  int   ncmp  = 0;
  int   nfail = 0;
  logic mon_en = 1'b1;
  int   n_ovs = 0;
  int   n_half = 0;
  int   n_bit = 0;

  task automatic push(input int c, input logic o, input logic h, input logic b);
    exp_t e;
    e.c = c; e.o = o; e.h = h; e.b = b;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    ncmp++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge sysclk);
  endtask

  // Monitor: scoreboard mode pops on every presented tick, count mode tallies ticks.
  always @(negedge sysclk) begin
    if (reset && (ovs_tick || half_tick || bit_tick)) begin
      if (mon_en) begin
        ncmp++;
        if (exp_q.size() == 0) begin
          nfail++;
          $display("FAIL unexpected_tick: cycle %0d ovs=%b half=%b bit=%b, required none",
                   cyc, ovs_tick, half_tick, bit_tick);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.c != cyc || e.o !== ovs_tick || e.h !== half_tick || e.b !== bit_tick) begin
            nfail++;
            $display("FAIL tick_event: got cycle %0d o/h/b=%b%b%b, required cycle %0d o/h/b=%b%b%b",
                     cyc, ovs_tick, half_tick, bit_tick, e.c, e.o, e.h, e.b);
          end
        end
      end else begin
        n_ovs  += int'(ovs_tick);
        n_half += int'(half_tick);
        n_bit  += int'(bit_tick);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  int base, r, w, z, y, s;

  initial begin
    #1 reset = 1'b0;
    #2;
    chk("rst_ovs", {31'd0, ovs_tick}, 32'd0);
    chk("rst_half", {31'd0, half_tick}, 32'd0);
    chk("rst_bit", {31'd0, bit_tick}, 32'd0);
    chk("rst_active", {31'd0, active}, 32'd0);
    chk("rst_inc_out", {8'd0, inc_out}, 32'd629146);

    // Period-2 ticks with inc = 2^23.
    @(negedge sysclk); reset = 1'b1;
    @(negedge sysclk); inc_wr = 1'b1; inc_in = 24'h800000;
    @(negedge sysclk); inc_wr = 1'b0;
    chk("inc_out_wr", {8'd0, inc_out}, 32'h800000);
    chk("active_en0", {31'd0, active}, 32'd0);
    en = 1'b1;
    base = cyc;
    for (int k = 1; k <= 55; k++) push(base + 2 * k, 1'b1, (k % 16) == 8, (k % 16) == 0);
    wait_cyc(base + 2);
    chk("active_en1", {31'd0, active}, 32'd1);

    // Restart at ovs_cnt=7, on the edge that would otherwise produce tick 56.
    wait_cyc(base + 111);
    restart = 1'b1;
    r = base + 112;
    for (int j = 1; j <= 16; j++) push(r + 2 * j, 1'b1, j == 8, j == 16);
    @(negedge sysclk); restart = 1'b0;
    chk("restart_ovs0", {31'd0, ovs_tick}, 32'd0);

    // 100-cycle enable gap: sequence resumes shifted by exactly 100 cycles.
    wait_cyc(r + 33);
    en = 1'b0;
    for (int j = 17; j <= 32; j++) push(r + 2 * j + 100, 1'b1, j == 24, j == 32);
    wait_cyc(r + 35);
    chk("active_gap", {31'd0, active}, 32'd0);
    wait_cyc(r + 133);
    en = 1'b1;

    // Mid-stream increment change to 2^22: period 4, counter keeps running.
    wait_cyc(r + 164);
    inc_wr = 1'b1; inc_in = 24'h400000;
    w = r + 165;
    for (int j = 33; j <= 48; j++) push(w + 2 + 4 * (j - 33), 1'b1, j == 40, j == 48);
    @(negedge sysclk); inc_wr = 1'b0;
    chk("inc_out_400000", {8'd0, inc_out}, 32'h400000);
    wait_cyc(w + 62);
    inc_wr = 1'b1; inc_in = '0;
    z = w + 63;
    @(negedge sysclk); inc_wr = 1'b0;
    chk("inc_out_zero", {8'd0, inc_out}, 32'd0);
    @(negedge sysclk);
    chk("active_inc0", {31'd0, active}, 32'd0);
    wait_cyc(z + 41);

    // Restore 2^23; acc held 2^22, so the first carry comes two adds after the write edge.
    inc_wr = 1'b1; inc_in = 24'h800000;
    y = z + 42;
    for (int j = 49; j <= 51; j++) push(y + 2 + 2 * (j - 49), 1'b1, 1'b0, 1'b0);
    @(negedge sysclk); inc_wr = 1'b0;
    wait_cyc(y + 6);
    #1;
    chk("tick_high_pre_reset", {31'd0, ovs_tick}, 32'd1);
    chk("queue_drained", exp_q.size(), 32'd0);
    reset = 1'b0;
    #1;
    chk("async_rst_ovs", {31'd0, ovs_tick}, 32'd0);
    chk("async_rst_half", {31'd0, half_tick}, 32'd0);
    chk("async_rst_bit", {31'd0, bit_tick}, 32'd0);
    chk("async_rst_active", {31'd0, active}, 32'd0);
    chk("async_rst_inc_out", {8'd0, inc_out}, 32'd629146);

    // Default rate for 1 ms at 49.152 MHz: 1843.2 oversample ticks, 115.2 bits.
    mon_en = 1'b0;
    en = 1'b0;
    @(negedge sysclk); reset = 1'b1;
    @(negedge sysclk); en = 1'b1;
    s = cyc + 1;
    wait_cyc(s + 49151);
    en = 1'b0;
    @(negedge sysclk);
    @(negedge sysclk);
    ncmp++;
    if (n_ovs < 1842 || n_ovs > 1844) begin
      nfail++;
      $display("FAIL rate_ovs_count: got %0d, required 1843 +/- 1", n_ovs);
    end
    ncmp++;
    if (n_bit < 114 || n_bit > 116) begin
      nfail++;
      $display("FAIL rate_bit_count: got %0d, required 115 +/- 1", n_bit);
    end
    ncmp++;
    if (n_half < 114 || n_half > 116) begin
      nfail++;
      $display("FAIL rate_half_count: got %0d, required 115 +/- 1", n_half);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
